frame_scheduler: RTL

- Sequences frame transmission on the clk_20 side of the pixel path, sitting between the pixel FIFO read side and the parallel string drivers.
- Releases a frame only when the pixel FIFO holds one complete frame.
- A frame is triggered either by a host blanking pulse or by an internal frame-rate timer.
- After the strings go idle, enforces the LED latch (reset) gap before the next frame is allowed.

---
 rtl/frame_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/frame_scheduler.sv
// frame_scheduler: sequences frame transmission on the clk_20 side of the pixel path.
// A frame is released when a request is pending (host trigger or internal frame-rate
// timer), the scheduler is enabled and the pixel FIFO holds at least one full frame.
// After the string drivers finish shifting, an LED latch gap is enforced before the
// next frame may be armed.
//
// Ports:
//   clk             in   system clock (clk_20 domain)
//   reset           in   asynchronous active-high reset
//   enable          in   level, allows new frames to be armed
//   auto_mode       in   level, 1 = timer requests, 0 = trigger requests
//   trigger         in   single-cycle request pulse (already synchronised)
//   clear_err       in   single-cycle pulse, clears sticky error flags
//   fifo_full_count in   pixel FIFO occupancy in words
//   string_active   in   high while the string drivers shift a frame
//   frame_start     out  single-cycle pulse starting the string drivers
//   busy            out  high whenever the scheduler is not idle
//   waiting         out  high while armed and waiting for FIFO data
//   frame_count     out  completed frames, wraps at 16 bits
//   missed_frame    out  sticky, request arrived while one was already pending
//   no_response     out  sticky, string_active never asserted after frame_start
module frame_scheduler #(
    parameter int unsigned FIFO_ADDR_WIDTH = 13,
    parameter int unsigned WORDS_PER_FRAME = 8142,
    parameter int unsigned LATCH_CYCLES    = 6000,
    parameter int unsigned FRAME_PERIOD    = 333333,
    parameter int unsigned PERIOD_WIDTH    = 20,
    parameter int unsigned START_TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     auto_mode,
    input  logic                     trigger,
    input  logic                     clear_err,
    input  logic [FIFO_ADDR_WIDTH:0] fifo_full_count,
    input  logic                     string_active,
    output logic                     frame_start,
    output logic                     busy,
    output logic                     waiting,
    output logic [15:0]              frame_count,
    output logic                     missed_frame,
    output logic                     no_response
);

    localparam int unsigned COUNT_WIDTH   = FIFO_ADDR_WIDTH + 1;
    localparam int unsigned LATCH_WIDTH   = $clog2(LATCH_CYCLES + 1);
    localparam int unsigned TIMEOUT_WIDTH = $clog2(START_TIMEOUT + 1);

    localparam logic [COUNT_WIDTH-1:0]   FRAME_WORDS = COUNT_WIDTH'(WORDS_PER_FRAME);
    localparam logic [PERIOD_WIDTH-1:0]  PERIOD_LAST = PERIOD_WIDTH'(FRAME_PERIOD - 1);
    localparam logic [LATCH_WIDTH-1:0]   LATCH_LAST  = LATCH_WIDTH'(LATCH_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] WAIT_LAST   = TIMEOUT_WIDTH'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        ACTIVE,
        LATCH
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic                      pending;
    logic                      pending_next;
    logic                      seen;
    logic                      seen_next;
    logic [PERIOD_WIDTH-1:0]   period_cnt;
    logic [PERIOD_WIDTH-1:0]   period_cnt_next;
    logic [LATCH_WIDTH-1:0]    latch_cnt;
    logic [LATCH_WIDTH-1:0]    latch_cnt_next;
    logic [TIMEOUT_WIDTH-1:0]  wait_cnt;
    logic [TIMEOUT_WIDTH-1:0]  wait_cnt_next;
    logic                      tick;
    logic                      request;
    logic                      arm;
    logic                      missed_set;
    logic                      timeout_set;
    logic                      frame_done;

    // Frame-rate timer: free-runs only in enabled auto mode, ticks on the wrap to 0.
    always_comb begin
        period_cnt_next = '0;
        tick            = 1'b0;
        if (enable && auto_mode) begin
            if (period_cnt == PERIOD_LAST) begin
                tick = 1'b1;
            end else begin
                period_cnt_next = period_cnt + PERIOD_WIDTH'(1);
            end
        end
    end

    // Request source and pending flag; a request racing the arm leaves pending set.
    always_comb begin
        request      = auto_mode ? tick : trigger;
        pending_next = request | (pending & ~arm);
        missed_set   = request & pending & ~arm;
    end

    // Next-state logic; START/ACTIVE/LATCH always run to completion.
    always_comb begin
        state_next     = state;
        seen_next      = 1'b0;
        wait_cnt_next  = '0;
        latch_cnt_next = '0;
        arm            = 1'b0;
        timeout_set    = 1'b0;
        frame_done     = 1'b0;
        case (state)
            IDLE: begin
                if (enable && pending) begin
                    state_next = ARMED;
                    arm        = 1'b1;
                end
            end
            ARMED: begin
                if (fifo_full_count >= FRAME_WORDS) begin
                    state_next = START;
                end else if (!enable) begin
                    state_next = IDLE;
                end
            end
            START: begin
                state_next = ACTIVE;
            end
            ACTIVE: begin
                seen_next     = seen | string_active;
                wait_cnt_next = wait_cnt + TIMEOUT_WIDTH'(1);
                if (seen && !string_active) begin
                    state_next = LATCH;
                end else if (!seen && !string_active && (wait_cnt == WAIT_LAST)) begin
                    state_next  = LATCH;
                    timeout_set = 1'b1;
                end
            end
            LATCH: begin
                latch_cnt_next = latch_cnt + LATCH_WIDTH'(1);
                if (latch_cnt == LATCH_LAST) begin
                    state_next     = IDLE;
                    latch_cnt_next = '0;
                    frame_done     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs (decoded from the next state).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= 1'b0;
            seen         <= 1'b0;
            period_cnt   <= '0;
            latch_cnt    <= '0;
            wait_cnt     <= '0;
            frame_start  <= 1'b0;
            busy         <= 1'b0;
            waiting      <= 1'b0;
            frame_count  <= '0;
            missed_frame <= 1'b0;
            no_response  <= 1'b0;
        end else begin
            state        <= state_next;
            pending      <= pending_next;
            seen         <= seen_next;
            period_cnt   <= period_cnt_next;
            latch_cnt    <= latch_cnt_next;
            wait_cnt     <= wait_cnt_next;
            frame_start  <= (state_next == START);
            busy         <= (state_next != IDLE);
            waiting      <= (state_next == ARMED);
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
            missed_frame <= missed_set | (missed_frame & ~clear_err);
            no_response  <= timeout_set | (no_response & ~clear_err);
        end
    end

endmodule
